fft_frame_buffer: RTL and testbench

Receiving end of the Hamming window output interface. Captures the windowed samples of one frame into an NFFT-deep buffer, indexed by the producer's frame pointer, and zero-pads entries FRAME_SIZE..NFFT_SIZE-1. It then streams the NFFT samples to the FFT stage over a valid/ready interface. When the frame has been fully consumed, it pulses `frame_consumed_o`, which drives the window buffer's start-move request.

---
 rtl/fft_frame_buffer.sv | 156 +++++++++++++++
 tb/tb_fft_frame_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_buffer
// Purpose  : Captures one frame of windowed samples into an NFFT-deep buffer
//            indexed by the producer's frame pointer. It zero-pads entries
//            FRAME_SIZE..NFFT_SIZE-1, then streams all NFFT samples to the FFT
//            over valid/ready. It pulses frame_consumed_o once the last sample
//            has been accepted.
// Ports    : clk, rst_n (async, active low)
//            in_valid_i / in_ptr_i / in_sample_i / in_done_i / in_ready_o
//                                      - window-side write port
//            out_valid_o / out_ready_i / out_sample_o / out_index_o /
//            out_last_o                - FFT-side stream
//            frame_consumed_o          - one-cycle pulse after the last handshake
//            overrun_o                 - sticky error flag, cleared only by reset
// Config   : FFT_BITREV_OUT_EN - when defined, the stream reads mem[bitrev(k)];
//            otherwise it reads mem[k].
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_buffer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 400,
  parameter int NFFT_SIZE    = 512,
  parameter int ADDR_W       = $clog2(NFFT_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  input  logic [ADDR_W-1:0]       in_ptr_i,
  input  logic [SAMPLE_WIDTH-1:0] in_sample_i,
  input  logic                    in_done_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SAMPLE_WIDTH-1:0] out_sample_o,
  output logic [ADDR_W-1:0]       out_index_o,
  output logic                    out_last_o,
  output logic                    frame_consumed_o,
  output logic                    overrun_o
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_PAD    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  // One extra bit so FRAME_SIZE == NFFT_SIZE is representable in the compare.
  localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W+1)'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] PAD_START = ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NFFT_SIZE - 1);
  localparam bit                HAS_PAD   = (FRAME_SIZE < NFFT_SIZE);

  logic [SAMPLE_WIDTH-1:0] mem [NFFT_SIZE];

  state_t                  state, next_state;
  logic [ADDR_W-1:0]       pad_addr;
  logic [ADDR_W-1:0]       rd_k;          // next stream position to fetch
  logic [ADDR_W-1:0]       rd_addr;
  logic                    fetch_pending; // positions remain to be fetched
  logic                    ptr_in_frame;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [SAMPLE_WIDTH-1:0] wr_data;
  logic                    load;
  logic                    handshake;

  assign ptr_in_frame = ({1'b0, in_ptr_i} < FRAME_LIM);
  assign in_ready_o   = (state == S_FILL);
  assign handshake    = out_valid_o && out_ready_i;
  // Read-ahead: refill the output register whenever it is empty or being drained.
  assign load         = (state == S_STREAM) && fetch_pending && (!out_valid_o || out_ready_i);

`ifdef FFT_BITREV_OUT_EN
  for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
    assign rd_addr[i] = rd_k[ADDR_W-1-i];
  end
`else
  assign rd_addr = rd_k;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_addr    = in_ptr_i;
    wr_data    = in_sample_i;
    case (state)
      S_FILL: begin
        wr_en = in_valid_i && ptr_in_frame;
        if (in_done_i) next_state = HAS_PAD ? S_PAD : S_STREAM;
      end
      S_PAD: begin
        wr_en   = 1'b1;
        wr_addr = pad_addr;
        wr_data = '0;
        if (pad_addr == LAST_K) next_state = S_STREAM;
      end
      S_STREAM: begin
        if (handshake && out_last_o) next_state = S_FILL;
      end
      default: next_state = S_FILL;
    endcase
  end

  // Buffer storage has no reset; its contents persist across frames.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_addr         <= PAD_START;
      rd_k             <= '0;
      fetch_pending    <= 1'b1;
      out_valid_o      <= 1'b0;
      out_sample_o     <= '0;
      out_index_o      <= '0;
      out_last_o       <= 1'b0;
      frame_consumed_o <= 1'b0;
      overrun_o        <= 1'b0;
    end else begin
      frame_consumed_o <= 1'b0;

      if ((in_valid_i && !(state == S_FILL && ptr_in_frame)) ||
          (in_done_i && state != S_FILL))
        overrun_o <= 1'b1;

      if (state == S_PAD) pad_addr <= pad_addr + 1'b1;
      else                pad_addr <= PAD_START;

      if (state != S_STREAM) begin
        rd_k          <= '0;
        fetch_pending <= 1'b1;
      end else if (load) begin
        out_sample_o <= mem[rd_addr];
        out_index_o  <= rd_k;
        out_last_o   <= (rd_k == LAST_K);
        out_valid_o  <= 1'b1;
        if (rd_k == LAST_K) fetch_pending <= 1'b0;
        else                rd_k          <= rd_k + 1'b1;
      end else if (handshake) begin
        // Only reached for the final sample: nothing left to fetch.
        out_valid_o      <= 1'b0;
        out_last_o       <= 1'b0;
        frame_consumed_o <= out_last_o;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_buffer
// Purpose  : Directed self-checking bench for fft_frame_buffer (default
//            parameters). Covers natural or bit-reversed order depending on
//            FFT_BITREV_OUT_EN, backpressure, overrun, simultaneous
//            valid+done, and reset in the middle of a stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_buffer;
  localparam int SW = 16;
  localparam int FS = 400;
  localparam int NF = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_ptr = '0;
  logic [SW-1:0] in_sample = '0;
  logic          in_done = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_sample;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          frame_consumed;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  logic [SW-1:0] model [NF];

  fft_frame_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid),
    .in_ptr_i         (in_ptr),
    .in_sample_i      (in_sample),
    .in_done_i        (in_done),
    .in_ready_o       (in_ready),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_sample_o     (out_sample),
    .out_index_o      (out_index),
    .out_last_o       (out_last),
    .frame_consumed_o (frame_consumed),
    .overrun_o        (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] pat(input int mode, input int p);
    case (mode)
      0:       return SW'(p + 1);
      1:       return 16'hA000 ^ SW'(p * 3);
      2:       return 16'h8000 + SW'(p);
      default: return SW'(p * 5);
    endcase
  endfunction

  function automatic int addr_of(input int k);
    logic [AW-1:0] kk, r;
    kk = AW'(k);
`ifdef FFT_BITREV_OUT_EN
    for (int i = 0; i < AW; i++) r[i] = kk[AW-1-i];
`else
    r = kk;
`endif
    return int'(r);
  endfunction

  function automatic logic [SW-1:0] exp_at(input int k);
    int a;
    a = addr_of(k);
    return (a < FS) ? model[a] : '0;
  endfunction

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        frame_consumed !== 1'b0 || overrun !== 1'b0 || out_sample !== '0 || out_index !== '0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b vld=%b last=%b fc=%b ovr=%b smp=%h idx=%0d, required 1 0 0 0 0 0000 0",
               in_ready, out_valid, out_last, frame_consumed, overrun, out_sample, out_index);
    end
  endtask

  // Writes ptr 0..FS-1 with pattern values; optionally one bad ptr mid-frame,
  // and done either alongside the last write (value 0x7FFF) or one cycle after.
  // Then checks the done-to-out_valid latency.
  task automatic fill_frame(input int mode, input bit done_with_last, input int bad_ptr);
    int edges;
    for (int p = 0; p < FS; p++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_ptr    = AW'(p);
      in_sample = pat(mode, p);
      model[p]  = pat(mode, p);
      if (done_with_last && p == FS - 1) begin
        in_sample = 16'h7FFF;
        model[p]  = 16'h7FFF;
        in_done   = 1'b1;
      end
      if (bad_ptr >= 0 && p == 200) begin
        @(negedge clk);
        in_ptr    = AW'(bad_ptr);
        in_sample = 16'h1234;
      end
    end
    if (!done_with_last) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_done  = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_done  = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pad_not_ready: in_ready=%b, required 0", in_ready);
    end
    edges = 0;
    while (out_valid !== 1'b1 && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (edges != 113) begin
      failures++;
      $display("FAIL done_to_valid_latency: %0d cycles, required 113", edges);
    end
  endtask

  // Consumes one frame. stall_mode 1 toggles ready and holds it low for 10
  // cycles at k=NF-1. inject_k >= 0 issues an illegal write during STREAM.
  // abort_k >= 0 resets the DUT at that stream position.
  task automatic stream_frame(input int stall_mode, input int inject_k, input int abort_k);
    int k, cyc, st_last, quiet_bad;
    bit prev_stall;
    logic [SW-1:0] held_s;
    logic [AW-1:0] held_i;
    k = 0; cyc = 0; st_last = 0; prev_stall = 1'b0;
    held_s = '0; held_i = '0;
    while (k < NF && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (abort_k >= 0 && k == abort_k) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            frame_consumed !== 1'b0 || overrun !== 1'b0 || out_sample !== '0 || out_index !== '0) begin
          failures++;
          $display("FAIL abort_reset_values: rdy=%b vld=%b last=%b fc=%b ovr=%b smp=%h idx=%0d, required 1 0 0 0 0 0000 0",
                   in_ready, out_valid, out_last, frame_consumed, overrun, out_sample, out_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (frame_consumed !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) quiet_bad++;
        end
        checks++;
        if (quiet_bad != 0) begin
          failures++;
          $display("FAIL abort_quiet: %0d bad cycles after reset, required 0", quiet_bad);
        end
        return;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_sample !== held_s || out_index !== held_i) begin
          failures++;
          $display("FAIL stall_stable: vld=%b smp=%h idx=%0d, required 1 %h %0d",
                   out_valid, out_sample, out_index, held_s, held_i);
        end
      end
      out_ready = (stall_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (stall_mode != 0 && out_valid === 1'b1 && out_index == AW'(NF - 1) && st_last < 10) begin
        out_ready = 1'b0;
        st_last++;
      end
      if (inject_k >= 0 && k == inject_k) begin
        in_valid  = 1'b1;
        in_ptr    = 9'd300;
        in_sample = 16'hDEAD;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_sample !== exp_at(k) || out_index !== AW'(k) || out_last !== (k == NF - 1)) begin
          failures++;
          $display("FAIL stream_k%0d: smp=%h idx=%0d last=%b, required %h %0d %b",
                   k, out_sample, out_index, out_last, exp_at(k), k, (k == NF - 1));
        end
        k++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      held_s = out_sample;
      held_i = out_index;
    end
    checks++;
    if (k != NF) begin
      failures++;
      $display("FAIL stream_count: %0d handshakes, required %0d", k, NF);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (frame_consumed !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL consumed_pulse: fc=%b rdy=%b vld=%b, required 1 1 0", frame_consumed, in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_consumed !== 1'b0) begin
      failures++;
      $display("FAIL consumed_width: fc=%b, required 0", frame_consumed);
    end
  endtask

  task automatic test_natural_frame();
    fill_frame(0, 1'b0, -1);
    stream_frame(0, -1, -1);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL no_spurious_overrun: overrun=%b, required 0", overrun);
    end
  endtask

  task automatic test_backpressure();
    fill_frame(1, 1'b0, -1);
    stream_frame(1, -1, -1);
  endtask

  task automatic test_overrun();
    fill_frame(2, 1'b0, 450);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: overrun=%b, required 1", overrun);
    end
    stream_frame(0, 100, -1);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
    end
  endtask

  task automatic test_simultaneous();
    fill_frame(3, 1'b1, -1);
    stream_frame(0, -1, -1);
  endtask

  task automatic test_reset_mid_stream();
    fill_frame(0, 1'b0, -1);
    stream_frame(0, -1, 200);
    fill_frame(1, 1'b0, -1);
    stream_frame(1, -1, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_natural_frame();
    test_backpressure();
    test_overrun();
    test_simultaneous();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
